// File: rtl/sim_commit_monitor.sv
// Simulation commit monitor: counts cycles and retired instructions and records the first
// trap or watchdog timeout. After a fixed drain period it raises difftest_exit.
module sim_commit_monitor #(
    parameter int COMMIT_WIDTH   = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [COMMIT_WIDTH-1:0]   commit_valid,
    input  logic [COMMIT_WIDTH-1:0]   commit_is_trap,
    input  logic [8*COMMIT_WIDTH-1:0] commit_trap_code,
    input  logic [64*COMMIT_WIDTH-1:0] commit_pc,
    input  logic                      perf_clean,
    input  logic                      perf_dump,
    output logic [63:0]               cycle_cnt,
    output logic [63:0]               instr_cnt,
    output logic [63:0]               snap_cycle_cnt,
    output logic [63:0]               snap_instr_cnt,
    output logic                      has_trap,
    output logic [7:0]                trap_code,
    output logic [63:0]               trap_pc,
    output logic                      timeout,
    output logic                      difftest_exit,
    output logic                      difftest_step
);

    localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t             state, state_next;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [63:0]        last_pc;

    logic               in_run;
    logic               any_valid;
    logic               trap_found;
    logic [3:0]         counted;
    logic [7:0]         lane_code;
    logic [63:0]        lane_pc;
    logic [63:0]        last_lane_pc;
    logic               trap_hit;
    logic               timeout_hit;
    logic [63:0]        counted_run;

    // Lanes retire in order, so counting stops at the oldest trapping lane.
    always_comb begin
        trap_found   = 1'b0;
        counted      = '0;
        lane_code    = '0;
        lane_pc      = '0;
        last_lane_pc = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (commit_valid[i] && !trap_found) begin
                counted      = counted + 4'd1;
                last_lane_pc = commit_pc[64*i +: 64];
                if (commit_is_trap[i]) begin
                    trap_found = 1'b1;
                    lane_code  = commit_trap_code[8*i +: 8];
                    lane_pc    = commit_pc[64*i +: 64];
                end
            end
        end
    end

    assign in_run      = (state == RUN);
    assign any_valid   = |commit_valid;
    assign trap_hit    = in_run && trap_found;
    assign timeout_hit = in_run && !any_valid && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign counted_run = in_run ? 64'(counted) : 64'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (trap_hit || timeout_hit) state_next = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        difftest_exit = (state == DONE);
        difftest_step = (state != DONE);
    end

    // NOTE: every register here uses <= so all updates see the same pre-edge values,
    // which is what lets perf_dump capture the pre-clean counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt      <= '0;
            instr_cnt      <= '0;
            snap_cycle_cnt <= '0;
            snap_instr_cnt <= '0;
            idle_cnt       <= '0;
            drain_cnt      <= '0;
            last_pc        <= '0;
            has_trap       <= 1'b0;
            trap_code      <= '0;
            trap_pc        <= '0;
            timeout        <= 1'b0;
        end else begin
            if (perf_dump) begin
                snap_cycle_cnt <= cycle_cnt;
                snap_instr_cnt <= instr_cnt;
            end

            if (perf_clean)         cycle_cnt <= '0;
            else if (state != DONE) cycle_cnt <= cycle_cnt + 64'd1;

            if (perf_clean) instr_cnt <= counted_run;
            else            instr_cnt <= instr_cnt + counted_run;

            if (in_run) begin
                if (any_valid) last_pc <= last_lane_pc;
                idle_cnt <= any_valid ? '0 : idle_cnt + 1'b1;
            end

            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

            // A trap implies a valid lane, so it always wins over the watchdog.
            if (trap_hit) begin
                has_trap  <= 1'b1;
                trap_code <= lane_code;
                trap_pc   <= lane_pc;
            end else if (timeout_hit) begin
                has_trap  <= 1'b1;
                timeout   <= 1'b1;
                trap_code <= 8'hFF;
                trap_pc   <= last_pc;
            end
        end
    end

endmodule

// File: tb/tb_sim_commit_monitor.sv
// Directed bench for sim_commit_monitor: a vector table for the main commit/trap/drain flow,
// then hand-written sequences for perf dump/clean, async reset in DRAIN and the watchdog.
module tb_sim_commit_monitor;

    localparam int CW = 2;

    logic          clock;
    logic          reset;
    logic [1:0]    commit_valid;
    logic [1:0]    commit_is_trap;
    logic [15:0]   commit_trap_code;
    logic [127:0]  commit_pc;
    logic          perf_clean;
    logic          perf_dump;
    logic [63:0]   cycle_cnt, instr_cnt, snap_cycle_cnt, snap_instr_cnt;
    logic          has_trap;
    logic [7:0]    trap_code;
    logic [63:0]   trap_pc;
    logic          timeout;
    logic          difftest_exit;
    logic          difftest_step;

    int n_checks = 0;
    int n_errors = 0;

    sim_commit_monitor #(
        .COMMIT_WIDTH  (CW),
        .TIMEOUT_CYCLES(8),
        .DRAIN_CYCLES  (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .commit_valid    (commit_valid),
        .commit_is_trap  (commit_is_trap),
        .commit_trap_code(commit_trap_code),
        .commit_pc       (commit_pc),
        .perf_clean      (perf_clean),
        .perf_dump       (perf_dump),
        .cycle_cnt       (cycle_cnt),
        .instr_cnt       (instr_cnt),
        .snap_cycle_cnt  (snap_cycle_cnt),
        .snap_instr_cnt  (snap_instr_cnt),
        .has_trap        (has_trap),
        .trap_code       (trap_code),
        .trap_pc         (trap_pc),
        .timeout         (timeout),
        .difftest_exit   (difftest_exit),
        .difftest_step   (difftest_step)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]   valid;
        logic [1:0]   trap;
        logic [15:0]  code;
        logic [127:0] pc;
        logic [63:0]  exp_cycle;
        logic [63:0]  exp_instr;
        logic         exp_has_trap;
        logic [7:0]   exp_code;
        logic [63:0]  exp_pc;
        logic         exp_exit;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] trap,
                                input logic [15:0] code, input logic [127:0] pc,
                                input logic [63:0] exp_cycle, input logic [63:0] exp_instr,
                                input logic exp_has_trap, input logic [7:0] exp_code,
                                input logic [63:0] exp_pc, input logic exp_exit);
        vec_t v;
        v.valid = valid;  v.trap = trap;  v.code = code;  v.pc = pc;
        v.exp_cycle = exp_cycle;  v.exp_instr = exp_instr;
        v.exp_has_trap = exp_has_trap;  v.exp_code = exp_code;
        v.exp_pc = exp_pc;  v.exp_exit = exp_exit;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        commit_valid     = '0;
        commit_is_trap   = '0;
        commit_trap_code = '0;
        commit_pc        = '0;
        perf_clean       = 1'b0;
        perf_dump        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    localparam logic [63:0] PC_A = 64'h0000_0000_8000_0100;
    localparam logic [63:0] PC_B = 64'h0000_0000_8000_0104;
    localparam logic [63:0] PC_T = 64'h0000_0000_8000_0010;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 10; i++)
            vecs[i] = mk(2'b11, 2'b00, 16'h0, {PC_B, PC_A},
                         64'(i + 1), 64'(2 * (i + 1)), 1'b0, 8'h00, 64'h0, 1'b0);
        vecs[10] = mk(2'b01, 2'b00, 16'h0, {PC_B, PC_A}, 64'd11, 64'd21, 1'b0, 8'h00, 64'h0, 1'b0);
        vecs[11] = mk(2'b10, 2'b00, 16'h0, {PC_B, PC_A}, 64'd12, 64'd22, 1'b0, 8'h00, 64'h0, 1'b0);
        vecs[12] = mk(2'b00, 2'b00, 16'h0, {PC_B, PC_A}, 64'd13, 64'd22, 1'b0, 8'h00, 64'h0, 1'b0);
        // Trap on lane 0 with lane 1 valid: only lane 0 is counted.
        vecs[13] = mk(2'b11, 2'b01, 16'h5500, {PC_B, PC_T}, 64'd14, 64'd23, 1'b1, 8'h00, PC_T, 1'b0);
        // DRAIN: commits, even trapping ones, are ignored.
        for (int i = 14; i < 17; i++)
            vecs[i] = mk(2'b11, 2'b11, 16'h7777, {PC_B, PC_A},
                         64'(i + 1), 64'd23, 1'b1, 8'h00, PC_T, 1'b0);
        vecs[17] = mk(2'b11, 2'b11, 16'h7777, {PC_B, PC_A}, 64'd18, 64'd23, 1'b1, 8'h00, PC_T, 1'b1);
        vecs[18] = mk(2'b11, 2'b00, 16'h0,    {PC_B, PC_A}, 64'd18, 64'd23, 1'b1, 8'h00, PC_T, 1'b1);

        // Reset state.
        clear_inputs();
        reset = 1'b1;
        #3;
        check("reset_cycle", cycle_cnt, 64'd0);
        check("reset_instr", instr_cnt, 64'd0);
        check("reset_has_trap", 64'(has_trap), 64'd0);
        check("reset_step", 64'(difftest_step), 64'd1);
        check("reset_exit", 64'(difftest_exit), 64'd0);
        #9;
        reset = 1'b0;

        // Table: main commit flow, trap on lane 0, drain of 4 cycles, DONE hold.
        for (int i = 0; i < 19; i++) begin
            commit_valid     = vecs[i].valid;
            commit_is_trap   = vecs[i].trap;
            commit_trap_code = vecs[i].code;
            commit_pc        = vecs[i].pc;
            tick();
            check($sformatf("v%0d_cycle", i), cycle_cnt, vecs[i].exp_cycle);
            check($sformatf("v%0d_instr", i), instr_cnt, vecs[i].exp_instr);
            check($sformatf("v%0d_has_trap", i), 64'(has_trap), 64'(vecs[i].exp_has_trap));
            check($sformatf("v%0d_trap_code", i), 64'(trap_code), 64'(vecs[i].exp_code));
            check($sformatf("v%0d_trap_pc", i), trap_pc, vecs[i].exp_pc);
            check($sformatf("v%0d_timeout", i), 64'(timeout), 64'd0);
            check($sformatf("v%0d_exit", i), 64'(difftest_exit), 64'(vecs[i].exp_exit));
            check($sformatf("v%0d_step", i), 64'(difftest_step), 64'(!vecs[i].exp_exit));
        end

        // perf_dump and perf_clean together at cycle_cnt = 100.
        do_reset();
        commit_valid = 2'b01;
        commit_pc    = {PC_B, PC_A};
        repeat (100) tick();
        check("pre_dump_cycle", cycle_cnt, 64'd100);
        check("pre_dump_instr", instr_cnt, 64'd100);
        commit_valid = 2'b11;
        perf_dump    = 1'b1;
        perf_clean   = 1'b1;
        tick();
        clear_inputs();
        check("dump_snap_cycle", snap_cycle_cnt, 64'd100);
        check("dump_snap_instr", snap_instr_cnt, 64'd100);
        check("clean_cycle", cycle_cnt, 64'd0);
        check("clean_instr", instr_cnt, 64'd2);
        tick();
        check("post_clean_cycle", cycle_cnt, 64'd1);
        check("post_clean_instr", instr_cnt, 64'd2);
        check("post_clean_snap", snap_cycle_cnt, 64'd100);

        // Asynchronous reset in the middle of DRAIN.
        do_reset();
        commit_valid     = 2'b01;
        commit_is_trap   = 2'b01;
        commit_trap_code = 16'h0033;
        commit_pc        = {PC_B, PC_T};
        tick();
        clear_inputs();
        check("drain_entry_trap", 64'(has_trap), 64'd1);
        check("drain_entry_code", 64'(trap_code), 64'h33);
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_cycle", cycle_cnt, 64'd0);
        check("async_rst_instr", instr_cnt, 64'd0);
        check("async_rst_snap", snap_cycle_cnt | snap_instr_cnt, 64'd0);
        check("async_rst_has_trap", 64'(has_trap), 64'd0);
        check("async_rst_code", 64'(trap_code), 64'd0);
        check("async_rst_pc", trap_pc, 64'd0);
        check("async_rst_timeout", 64'(timeout), 64'd0);
        check("async_rst_exit", 64'(difftest_exit), 64'd0);
        check("async_rst_step", 64'(difftest_step), 64'd1);
        #1;
        reset = 1'b0;
        tick();
        check("resume_cycle", cycle_cnt, 64'd1);

        // Watchdog with no commits at all.
        do_reset();
        repeat (7) tick();
        check("to_before", 64'(timeout), 64'd0);
        tick();
        check("to_fire", 64'(timeout), 64'd1);
        check("to_has_trap", 64'(has_trap), 64'd1);
        check("to_code", 64'(trap_code), 64'hFF);
        check("to_pc", trap_pc, 64'd0);
        check("to_cycle", cycle_cnt, 64'd8);
        repeat (3) tick();
        check("to_drain_exit", 64'(difftest_exit), 64'd0);
        tick();
        check("to_done_exit", 64'(difftest_exit), 64'd1);
        check("to_done_step", 64'(difftest_step), 64'd0);

        // Watchdog reports the highest counted lane's PC from the last commit.
        do_reset();
        commit_valid = 2'b11;
        commit_pc    = {PC_B, PC_A};
        tick();
        clear_inputs();
        repeat (7) tick();
        check("to2_before", 64'(timeout), 64'd0);
        tick();
        check("to2_fire", 64'(timeout), 64'd1);
        check("to2_pc", trap_pc, PC_B);

        // Trap arriving on the cycle the watchdog would fire; lane 0 wins over lane 1.
        do_reset();
        repeat (7) tick();
        commit_valid     = 2'b11;
        commit_is_trap   = 2'b11;
        commit_trap_code = 16'h2211;
        commit_pc        = {PC_B, PC_A};
        tick();
        clear_inputs();
        check("coin_has_trap", 64'(has_trap), 64'd1);
        check("coin_code", 64'(trap_code), 64'h11);
        check("coin_pc", trap_pc, PC_A);
        check("coin_timeout", 64'(timeout), 64'd0);
        check("coin_instr", instr_cnt, 64'd1);
        repeat (8) tick();
        check("coin_timeout_late", 64'(timeout), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
